cfg_membank_loader: RTL and testbench



---
 rtl/cfg_membank_pkg.sv | 33 +++
 rtl/cfg_row_assembler.sv | 59 +++++
 rtl/cfg_membank_loader.sv | 196 +++++++++++++++++++
 tb/tb_cfg_membank_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_membank_pkg.sv
// ============================================================================
// Module  : cfg_membank_pkg
// Brief   : Shared types, default widths and helpers for the memory-bank
//           configuration loader (optional feature macro: CFG_CHECKSUM_EN).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package cfg_membank_pkg;

    localparam int c_BL_W_DEFAULT     = 514;
    localparam int c_WL_W_DEFAULT     = 407;
    localparam int c_DATA_W_DEFAULT   = 32;
    localparam int c_WL_PULSE_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_t;

    function automatic int words_per_row(input int bl_w, input int data_w);
        return (bl_w + data_w - 1) / data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_row_assembler.sv
// ============================================================================
// Module  : cfg_row_assembler
// Brief   : Collects stream words into one BL_W-bit row; word k bit j lands
//           on row bit k*DATA_W+j, bits past BL_W are dropped.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cfg_row_assembler
    import cfg_membank_pkg::*;
#(
    parameter int BL_W   = c_BL_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int WPR    = words_per_row(BL_W, DATA_W),
    parameter int CNT_W  = $clog2(WPR + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [0:BL_W-1]   o_row_data,
    output logic [CNT_W-1:0]  o_word_cnt
);

    logic [CNT_W-1:0] r_word_cnt;
    logic [0:BL_W-1]  r_row;
    logic             w_last;

    assign w_last = (r_word_cnt == CNT_W'(WPR - 1));

    // Count wraps at the end of each row so the next row starts at word 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word_cnt <= '0;
        end else if (i_wr_en) begin
            r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
        end
    end

    // Iterating over real row bits only means padding bits have no storage.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < BL_W; i++) begin
                if (r_word_cnt == CNT_W'(i / DATA_W)) begin
                    r_row[i] <= i_wr_data[i % DATA_W];
                end
            end
        end
    end

    assign o_row_data = r_row;
    assign o_word_cnt = r_word_cnt;

endmodule

`default_nettype wire

// File: rtl/cfg_membank_loader.sv
// ============================================================================
// Module  : cfg_membank_loader
// Brief   : Streams a bitstream into the fabric memory bank row by row,
//           strobing one word line per row, then releases fabric reset.
//           Define CFG_CHECKSUM_EN to require an XOR trailer word.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cfg_membank_loader
    import cfg_membank_pkg::*;
#(
    parameter int BL_W     = c_BL_W_DEFAULT,
    parameter int WL_W     = c_WL_W_DEFAULT,
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int WL_PULSE = c_WL_PULSE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [0:BL_W-1]   bl_config_region,
    output logic [0:WL_W-1]   wl_config_region,
    output logic              global_resetn,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int c_WPR     = words_per_row(BL_W, DATA_W);
    localparam int c_CNT_W   = $clog2(c_WPR + 1);
    localparam int c_ROW_W   = $clog2(WL_W + 1);
    localparam int c_PULSE_W = $clog2(WL_PULSE + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_PULSE_W-1:0] r_pulse_cnt;
    logic [0:BL_W-1]      w_row_data;
    logic [c_CNT_W-1:0]   w_word_cnt;
    logic                 w_last_word;
    logic                 w_last_row;
    logic                 w_start_load;
    logic                 w_wr_en;
    logic                 w_drive_bl;
    logic                 w_pulse;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0]    r_csum;
`endif

    cfg_row_assembler #(
        .BL_W   (BL_W),
        .DATA_W (DATA_W),
        .WPR    (c_WPR),
        .CNT_W  (c_CNT_W)
    ) u_row_asm (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_start_load),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (s_data),
        .o_row_data (w_row_data),
        .o_word_cnt (w_word_cnt)
    );

    assign w_last_word = (w_word_cnt == c_CNT_W'(c_WPR - 1));
    assign w_last_row  = (r_row == c_ROW_W'(WL_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_start_load  = 1'b0;
        w_wr_en       = 1'b0;
        w_drive_bl    = 1'b0;
        w_pulse       = 1'b0;
        s_ready       = 1'b0;
        cfg_busy      = 1'b1;
        cfg_done      = 1'b0;
        global_resetn = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_busy = 1'b0;
                if (cfg_start) begin
                    w_start_load = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                w_wr_en = s_valid;
                if (s_valid && w_last_word) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_drive_bl   = 1'b1;
                w_next_state = ST_PULSE;
            end
            ST_PULSE: begin
                w_drive_bl = 1'b1;
                w_pulse    = 1'b1;
                if (r_pulse_cnt == c_PULSE_W'(WL_PULSE - 1)) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_drive_bl = 1'b1;
                if (w_last_row) begin
`ifdef CFG_CHECKSUM_EN
                    w_next_state = ST_CHECK;
`else
                    w_next_state = ST_DONE;
`endif
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
`ifdef CFG_CHECKSUM_EN
            ST_CHECK: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_next_state = (s_data == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            ST_ERROR: begin
                cfg_busy = 1'b0;
                if (cfg_start) begin
                    w_start_load = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
`endif
            ST_DONE: begin
                cfg_busy      = 1'b0;
                cfg_done      = 1'b1;
                global_resetn = 1'b1;
                if (cfg_start) begin
                    w_start_load = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row       <= '0;
            r_pulse_cnt <= '0;
        end else begin
            if (w_start_load) begin
                r_row <= '0;
            end else if (r_state == ST_HOLD && !w_last_row) begin
                r_row <= r_row + c_ROW_W'(1);
            end
            r_pulse_cnt <= (r_state == ST_PULSE) ? r_pulse_cnt + c_PULSE_W'(1) : '0;
        end
    end

`ifdef CFG_CHECKSUM_EN
    // Running XOR covers only row words; the trailer itself is never folded in.
    always_ff @(posedge clk) begin
        if (reset || w_start_load) begin
            r_csum <= '0;
        end else if (w_wr_en) begin
            r_csum <= r_csum ^ s_data;
        end
    end

    assign cfg_err = (r_state == ST_ERROR);
`else
    assign cfg_err = 1'b0;
`endif

    assign bl_config_region = w_drive_bl ? w_row_data : '0;

    generate
        for (genvar i = 0; i < WL_W; i++) begin : g_wl_decode
            assign wl_config_region[i] = w_pulse && (r_row == c_ROW_W'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cfg_membank_loader.sv
// ============================================================================
// Module  : tb_cfg_membank_loader
// Brief   : Directed table-driven bench for cfg_membank_loader (10x3 bank,
//           4-bit words); honours CFG_CHECKSUM_EN when defined.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cfg_membank_loader;

    localparam int BL_W     = 10;
    localparam int WL_W     = 3;
    localparam int DATA_W   = 4;
    localparam int WL_PULSE = 2;
`ifdef CFG_CHECKSUM_EN
    localparam int NWORDS   = 10;
`else
    localparam int NWORDS   = 9;
`endif
    localparam logic [3:0] STREAM [0:9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'h8, 4'h0, 4'h2, 4'h4};

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [0:BL_W-1]   bl;
    logic [0:WL_W-1]   wl;
    logic              global_resetn;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    always #5 clk = ~clk;

    cfg_membank_loader #(
        .BL_W     (BL_W),
        .WL_W     (WL_W),
        .DATA_W   (DATA_W),
        .WL_PULSE (WL_PULSE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_start        (cfg_start),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .bl_config_region (bl),
        .wl_config_region (wl),
        .global_resetn    (global_resetn),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err)
    );

    typedef struct {
        logic       start;
        logic       valid;
        logic [3:0] data;
        logic       rdy;
        logic [0:2] wl;
        int         blsel;   // 0..2 = row image, 3 = all zero
    } vec_t;

    vec_t          vt [1:21];
    logic [0:9]    row_bl [0:2];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Cycle 0 asserts cfg_start; entry i describes the cycle after edge i-1.
    task automatic run_load(input int last);
        logic [0:9] eb;
        @(negedge clk);
        cfg_start = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            cfg_start = vt[i].start;
            s_valid   = vt[i].valid;
            s_data    = vt[i].data;
            eb = (vt[i].blsel < 3) ? row_bl[vt[i].blsel] : 10'b0;
            chk("s_ready", i, {31'b0, s_ready}, {31'b0, vt[i].rdy});
            chk("wl", i, {29'b0, wl}, {29'b0, vt[i].wl});
            chk("bl", i, {22'b0, bl}, {22'b0, eb});
            chk("busy", i, {31'b0, cfg_busy}, 32'd1);
            chk("done", i, {31'b0, cfg_done}, 32'd0);
            chk("resetn", i, {31'b0, global_resetn}, 32'd0);
        end
    endtask

    task automatic finish_load(input logic [3:0] trailer);
        @(negedge clk);
        cfg_start = 1'b0;
`ifdef CFG_CHECKSUM_EN
        begin
            logic ok;
            ok = (trailer == 4'h4);
            chk("check_ready", 22, {31'b0, s_ready}, 32'd1);
            chk("check_busy", 22, {31'b0, cfg_busy}, 32'd1);
            chk("check_done", 22, {31'b0, cfg_done}, 32'd0);
            s_valid = 1'b1;
            s_data  = trailer;
            @(negedge clk);
            s_valid = 1'b0;
            chk("end_done", 23, {31'b0, cfg_done}, {31'b0, ok});
            chk("end_err", 23, {31'b0, cfg_err}, {31'b0, !ok});
            chk("end_resetn", 23, {31'b0, global_resetn}, {31'b0, ok});
            chk("end_ready", 23, {31'b0, s_ready}, 32'd0);
            chk("end_busy", 23, {31'b0, cfg_busy}, 32'd0);
        end
`else
        chk("end_done", 22, {31'b0, cfg_done}, 32'd1);
        chk("end_resetn", 22, {31'b0, global_resetn}, 32'd1);
        chk("end_busy", 22, {31'b0, cfg_busy}, 32'd0);
        chk("end_ready", 22, {31'b0, s_ready}, 32'd0);
        chk("end_wl", 22, {29'b0, wl}, 32'd0);
        chk("end_bl", 22, {22'b0, bl}, 32'd0);
        chk("end_err", 22, {31'b0, cfg_err}, 32'd0);
        s_valid = 1'b1;
        s_data  = trailer;
        @(negedge clk);
        s_valid = 1'b0;
        chk("done_hold", 23, {31'b0, cfg_done}, 32'd1);
        chk("done_ready", 23, {31'b0, s_ready}, 32'd0);
`endif
    endtask

    // Valid offered only on even cycles; every pulse cycle must show the right row.
    task automatic gapped_load();
        int idx = 0;
        int pulses [0:2] = '{0, 0, 0};
        bit seen_done = 1'b0;
        @(negedge clk);
        cfg_start = 1'b1;
        s_valid   = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            chk("gap_wl_onehot", cyc, {31'b0, ($countones(wl) <= 1)}, 32'd1);
            for (int r = 0; r < 3; r++) begin
                if (wl[r]) begin
                    pulses[r]++;
                    chk("gap_bl", cyc, {22'b0, bl}, {22'b0, row_bl[r]});
                end
            end
            if (cfg_done) seen_done = 1'b1;
            s_valid = (cyc % 2 == 0) && (idx < NWORDS) && !seen_done;
            s_data  = (idx < NWORDS) ? STREAM[idx] : 4'h0;
            if (s_valid && s_ready) idx++;
        end
        s_valid = 1'b0;
        chk("gap_done", 0, {31'b0, seen_done}, 32'd1);
        chk("gap_words", 0, idx, NWORDS);
        for (int r = 0; r < 3; r++) begin
            chk("gap_pulses", r, pulses[r], WL_PULSE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        row_bl[0] = 10'b1000010011;
        row_bl[1] = 10'b0010101011;
        row_bl[2] = 10'b0001000001;
        //         start valid data  rdy  wl      bl
        vt[1]  = '{1'b0, 1'b1, 4'h1, 1'b1, 3'b000, 3};
        vt[2]  = '{1'b0, 1'b1, 4'h2, 1'b1, 3'b000, 3};
        vt[3]  = '{1'b0, 1'b1, 4'h3, 1'b1, 3'b000, 3};
        vt[4]  = '{1'b0, 1'b1, 4'h9, 1'b0, 3'b000, 0};
        vt[5]  = '{1'b1, 1'b1, 4'h9, 1'b0, 3'b100, 0};
        vt[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b100, 0};
        vt[7]  = '{1'b0, 1'b1, 4'h9, 1'b0, 3'b000, 0};
        vt[8]  = '{1'b1, 1'b1, 4'h4, 1'b1, 3'b000, 3};
        vt[9]  = '{1'b0, 1'b1, 4'h5, 1'b1, 3'b000, 3};
        vt[10] = '{1'b0, 1'b1, 4'hF, 1'b1, 3'b000, 3};
        vt[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 1};
        vt[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b010, 1};
        vt[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b010, 1};
        vt[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1};
        vt[15] = '{1'b0, 1'b1, 4'h8, 1'b1, 3'b000, 3};
        vt[16] = '{1'b0, 1'b1, 4'h0, 1'b1, 3'b000, 3};
        vt[17] = '{1'b0, 1'b1, 4'h2, 1'b1, 3'b000, 3};
        vt[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 2};
        vt[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b001, 2};
        vt[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b001, 2};
        vt[21] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 2};

        reset     = 1'b1;
        cfg_start = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_wl", 0, {29'b0, wl}, 32'd0);
        chk("rst_bl", 0, {22'b0, bl}, 32'd0);
        chk("rst_resetn", 0, {31'b0, global_resetn}, 32'd0);
        chk("rst_done", 0, {31'b0, cfg_done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 4'hA;
            chk("idle_ready", i, {31'b0, s_ready}, 32'd0);
            chk("idle_busy", i, {31'b0, cfg_busy}, 32'd0);
            chk("idle_wl", i, {29'b0, wl}, 32'd0);
            chk("idle_bl", i, {22'b0, bl}, 32'd0);
            chk("idle_resetn", i, {31'b0, global_resetn}, 32'd0);
        end
        s_valid = 1'b0;

        run_load(21);
        finish_load(4'h4);

        gapped_load();

        run_load(12);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wl", 13, {29'b0, wl}, 32'd0);
        chk("midrst_bl", 13, {22'b0, bl}, 32'd0);
        chk("midrst_busy", 13, {31'b0, cfg_busy}, 32'd0);
        chk("midrst_ready", 13, {31'b0, s_ready}, 32'd0);
        chk("midrst_resetn", 13, {31'b0, global_resetn}, 32'd0);
        reset = 1'b0;
        run_load(21);
        finish_load(4'h4);

`ifdef CFG_CHECKSUM_EN
        run_load(21);
        finish_load(4'h4 ^ 4'h1);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("recover_ready", 0, {31'b0, s_ready}, 32'd1);
        chk("recover_err", 0, {31'b0, cfg_err}, 32'd0);
        chk("recover_busy", 0, {31'b0, cfg_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
